// File: rtl/parking_slot_allocator.sv
// Parking occupancy owner and barrier-gate sequencer.
// Takes gate entry/exit requests one at a time and keeps the occupancy
// register. Exit is served before entry. Each admitted car or freed slot
// opens the barrier for GATE_CYCLES cycles.
// Ports:
//   clk, rst_n     system clock; synchronous active-low reset
//   enter_req      entry request level, held until enter_ack/enter_rej
//   location       encoder result: [2]=lot full, [1:0]=free slot index
//   exit_req       exit request level, held until exit_ack/exit_err
//   exit_slot      slot being vacated
//   occ            occupancy register (bit i = slot i taken), feeds encoder
//   free_count     number of free slots, 0..4
//   assigned_slot  slot granted by the most recent enter_ack
//   enter_ack/enter_rej/exit_ack/exit_err  one-cycle result pulses
//   gate_open      barrier open
module parking_slot_allocator #(
    parameter int unsigned GATE_CYCLES = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter_req,
    input  logic [2:0] location,
    input  logic       exit_req,
    input  logic [1:0] exit_slot,
    output logic [3:0] occ,
    output logic [2:0] free_count,
    output logic [1:0] assigned_slot,
    output logic       enter_ack,
    output logic       enter_rej,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       occ_q, occ_d;
    logic [2:0]       free_q, free_d;
    logic [1:0]       asg_q, asg_d;
    logic             enter_ack_q, enter_ack_d;
    logic             enter_rej_q, enter_rej_d;
    logic             exit_ack_q, exit_ack_d;
    logic             exit_err_q, exit_err_d;
    logic             gate_q, gate_d;

    // Next-state, occupancy update and result pulses
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        occ_d       = occ_q;
        asg_d       = asg_q;
        gate_d      = gate_q;
        enter_ack_d = 1'b0;
        enter_rej_d = 1'b0;
        exit_ack_d  = 1'b0;
        exit_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (exit_req) begin
                    if (occ_q[exit_slot]) begin
                        occ_d[exit_slot] = 1'b0;
                        exit_ack_d       = 1'b1;
                        gate_d           = 1'b1;
                        timer_d          = '0;
                        state_d          = OPEN_OUT;
                    end else begin
                        // Slot already free: report and leave occupancy alone
                        exit_err_d = 1'b1;
                    end
                end else if (enter_req) begin
                    // Encoder result is cross-checked against occ before granting
                    if (!location[2] && !occ_q[location[1:0]]) begin
                        occ_d[location[1:0]] = 1'b1;
                        asg_d                = location[1:0];
                        enter_ack_d          = 1'b1;
                        gate_d               = 1'b1;
                        timer_d              = '0;
                        state_d              = OPEN_IN;
                    end else begin
                        enter_rej_d = 1'b1;
                        state_d     = WAIT_REL;
                    end
                end
            end

            OPEN_IN, OPEN_OUT: begin
                if (timer_q == LAST_CNT) begin
                    gate_d  = 1'b0;
                    timer_d = '0;
                    // A request still held after its own gate cycle must be released first
                    if (state_q == OPEN_IN) begin
                        state_d = enter_req ? WAIT_REL : IDLE;
                    end else begin
                        state_d = exit_req ? WAIT_REL : IDLE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            WAIT_REL: begin
                if (!enter_req && !exit_req) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        free_d = 3'd4 - (3'(occ_d[0]) + 3'(occ_d[1]) + 3'(occ_d[2]) + 3'(occ_d[3]));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            occ_q       <= '0;
            free_q      <= 3'd4;
            asg_q       <= '0;
            enter_ack_q <= 1'b0;
            enter_rej_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            exit_err_q  <= 1'b0;
            gate_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            free_q      <= free_d;
            asg_q       <= asg_d;
            enter_ack_q <= enter_ack_d;
            enter_rej_q <= enter_rej_d;
            exit_ack_q  <= exit_ack_d;
            exit_err_q  <= exit_err_d;
            gate_q      <= gate_d;
        end
    end

    assign occ           = occ_q;
    assign free_count    = free_q;
    assign assigned_slot = asg_q;
    assign enter_ack     = enter_ack_q;
    assign enter_rej     = enter_rej_q;
    assign exit_ack      = exit_ack_q;
    assign exit_err      = exit_err_q;
    assign gate_open     = gate_q;

endmodule
